// File: rtl/b2_msg_feeder.sv
// b2_msg_feeder
// Front end for the BLAKE2 hash core. Bytes arriving on the input stream are
// packed into BLOCK_BYTES-wide blocks. Each block is handed to the core
// with an init (first block) or next (later block) pulse. The running byte
// count goes out on 'length'. When the core returns the digest of the final
// block, it is held for the downstream consumer with a valid/ready handshake.
//
// The "final" command output is named final_cmd because "final" is a
// reserved word in SystemVerilog and cannot be used as a port name.

module b2_msg_feeder #(
   parameter int BLOCK_BYTES = 128,
   parameter int LEN_BITS    = 128,
   parameter int DIGEST_BITS = 88
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   input  logic                     in_last,
   output logic                     in_ready,
   output logic                     init,
   output logic                     next,
   output logic                     final_cmd,
   output logic [BLOCK_BYTES*8-1:0] block,
   output logic [LEN_BITS-1:0]      length,
   input  logic                     core_ready,
   input  logic                     core_digest_valid,
   input  logic [DIGEST_BITS-1:0]   core_digest,
   output logic                     dgst_valid,
   output logic [DIGEST_BITS-1:0]   dgst,
   input  logic                     dgst_ready
);

   localparam int IDX_BITS = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;

   typedef enum logic [2:0] {IDLE, FILL, ISSUE, BUSY, DONE} feederState_t;

   feederState_t               state;
   feederState_t               nextState;
   logic [IDX_BITS-1:0]        byteIdx;
   logic                       firstBlock;
   logic                       finalFlag;
   logic                       busyFirst;
   logic [BLOCK_BYTES*8-1:0]   blockReg;
   logic [LEN_BITS-1:0]        lengthReg;
   logic [DIGEST_BITS-1:0]     dgstReg;
   logic                       accept;

   assign accept = in_valid && in_ready;
   assign block  = blockReg;
   assign length = lengthReg;
   assign dgst   = dgstReg;

   // State register. Reset is asynchronous so that a message in flight is
   // abandoned at once, whatever the core is doing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. A block is closed when its last slot is filled or
   // when the source marks the end of the message. After a command, the
   // feeder waits in BUSY. For a non-final block, it waits for the core to
   // come back ready; the first BUSY cycle is skipped because the core only
   // drops ready one cycle after it takes the command. For the final block,
   // it waits for the digest instead.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (accept) begin
               nextState = in_last ? ISSUE : FILL;
            end
         end
         FILL: begin
            if (accept && (in_last || byteIdx == IDX_BITS'(BLOCK_BYTES - 1))) begin
               nextState = ISSUE;
            end
         end
         ISSUE: begin
            if (core_ready) begin
               nextState = BUSY;
            end
         end
         BUSY: begin
            if (finalFlag) begin
               if (core_digest_valid) begin
                  nextState = DONE;
               end
            end else if (!busyFirst && core_ready) begin
               nextState = FILL;
            end
         end
         DONE: begin
            if (dgst_ready) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Output decode. The command pulse is a pure function of being in ISSUE
   // with the core ready, so it lasts exactly the one cycle in which the core
   // takes it. in_ready is also held low while reset is asserted, so that
   // every output reads zero during reset.
   always_comb begin
      in_ready   = 1'b0;
      init       = 1'b0;
      next       = 1'b0;
      final_cmd  = 1'b0;
      dgst_valid = 1'b0;
      case (state)
         IDLE, FILL: begin
            in_ready = !rst;
         end
         ISSUE: begin
            if (core_ready) begin
               init      = firstBlock;
               next      = !firstBlock;
               final_cmd = finalFlag;
            end
         end
         DONE: begin
            dgst_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath. This logic packs the bytes into the block, keeps the running
   // length, and tracks the first-block and final flags. It clears the block
   // between blocks, and clears everything once the consumer has taken the
   // digest. length is only cleared at the end of a message, so it keeps
   // counting across blocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byteIdx    <= '0;
         firstBlock <= 1'b1;
         finalFlag  <= 1'b0;
         busyFirst  <= 1'b0;
         blockReg   <= '0;
         lengthReg  <= '0;
         dgstReg    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  blockReg[7:0] <= in_data;
                  byteIdx       <= IDX_BITS'(1);
                  lengthReg     <= lengthReg + LEN_BITS'(1);
                  finalFlag     <= in_last;
               end
            end
            FILL: begin
               if (accept) begin
                  blockReg[int'(byteIdx)*8 +: 8] <= in_data;
                  byteIdx   <= byteIdx + IDX_BITS'(1);
                  lengthReg <= lengthReg + LEN_BITS'(1);
                  finalFlag <= in_last;
               end
            end
            ISSUE: begin
               if (core_ready) begin
                  firstBlock <= 1'b0;
                  busyFirst  <= 1'b1;
               end
            end
            BUSY: begin
               busyFirst <= 1'b0;
               if (finalFlag) begin
                  if (core_digest_valid) begin
                     dgstReg <= core_digest;
                  end
               end else if (!busyFirst && core_ready) begin
                  blockReg <= '0;
                  byteIdx  <= '0;
               end
            end
            DONE: begin
               if (dgst_ready) begin
                  blockReg   <= '0;
                  lengthReg  <= '0;
                  byteIdx    <= '0;
                  firstBlock <= 1'b1;
                  finalFlag  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_b2_msg_feeder.sv
// tb_b2_msg_feeder
// Self-checking bench for b2_msg_feeder. A small hash-core model takes the
// commands, logs them, and returns a random digest after the final block.
// The expected commands come from slicing each message into fixed-size
// chunks. This is checked with a table of messages, a few random messages,
// and hand-written corner sequences: core stall, slow consumer, and reset
// mid-message.

module tb_b2_msg_feeder;

   localparam int BLOCK_BYTES = 128;
   localparam int LEN_BITS    = 128;
   localparam int DIGEST_BITS = 88;

   typedef logic [7:0] byteQueue[$];

   typedef struct {
      logic                     init;
      logic                     next;
      logic                     fin;
      logic [LEN_BITS-1:0]      len;
      logic [BLOCK_BYTES*8-1:0] blk;
   } cmdRecord;

   typedef struct {
      int msgLen;
      int fillMode;
      int readyDelay;
      int expBlocks;
      int expFinalLen;
   } vector_t;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     in_valid = 1'b0;
   logic [7:0]               in_data = 8'h00;
   logic                     in_last = 1'b0;
   logic                     in_ready;
   logic                     init;
   logic                     next;
   logic                     final_cmd;
   logic [BLOCK_BYTES*8-1:0] block;
   logic [LEN_BITS-1:0]      length;
   logic                     core_ready = 1'b0;
   logic                     core_digest_valid = 1'b0;
   logic [DIGEST_BITS-1:0]   core_digest = '0;
   logic                     dgst_valid;
   logic [DIGEST_BITS-1:0]   dgst;
   logic                     dgst_ready = 1'b0;

   int assertCount = 0;
   int failCount   = 0;

   cmdRecord               cmdLog[$];
   logic                   holdLow = 1'b0;
   logic                   cmdTaken = 1'b0;
   logic                   pendFinal = 1'b0;
   int                     coreCnt = 0;
   logic [DIGEST_BITS-1:0] lastDigest = '0;
   string                  flamingo = "flamingo";
   vector_t                vectors[6];

   b2_msg_feeder #(
      .BLOCK_BYTES(BLOCK_BYTES),
      .LEN_BITS(LEN_BITS),
      .DIGEST_BITS(DIGEST_BITS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_last(in_last),
      .in_ready(in_ready),
      .init(init),
      .next(next),
      .final_cmd(final_cmd),
      .block(block),
      .length(length),
      .core_ready(core_ready),
      .core_digest_valid(core_digest_valid),
      .core_digest(core_digest),
      .dgst_valid(dgst_valid),
      .dgst(dgst),
      .dgst_ready(dgst_ready)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Hash-core model. It runs on the falling edge. The core is ready while
   // idle, unless the test forces a stall. A command seen just before a
   // rising edge is logged. The core then goes busy for a few cycles and, for
   // a final block, returns a one-cycle random digest.
   always @(negedge clk) begin
      if (rst) begin
         core_ready        = 1'b0;
         core_digest_valid = 1'b0;
         cmdTaken          = 1'b0;
         pendFinal         = 1'b0;
         coreCnt           = 0;
      end else begin
         core_digest_valid = 1'b0;
         if (cmdTaken) begin
            core_ready = 1'b0;
            coreCnt    = 3;
            cmdTaken   = 1'b0;
         end else if (coreCnt > 0) begin
            coreCnt = coreCnt - 1;
            if (coreCnt == 0 && pendFinal) begin
               lastDigest        = {$urandom, $urandom, 24'($urandom)};
               core_digest       = lastDigest;
               core_digest_valid = 1'b1;
               pendFinal         = 1'b0;
            end
         end else begin
            core_ready = !holdLow;
         end
         #1;
         if (core_ready && (init || next)) begin
            cmdRecord rec;
            rec.init  = init;
            rec.next  = next;
            rec.fin   = final_cmd;
            rec.len   = length;
            rec.blk   = block;
            cmdLog.push_back(rec);
            cmdTaken  = 1'b1;
            pendFinal = final_cmd;
         end
      end
   end

   // Global watchdog, so that a stuck design can never hang the run.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one value and keep the running counts.
   task automatic checkOutput(input string name, input logic [BLOCK_BYTES*8-1:0] act,
                              input logic [BLOCK_BYTES*8-1:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Record an expired wait as a failed comparison.
   task automatic failTimeout(input string name);
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: got timeout expected event", name);
   endtask

   // Build a message: 0 = random bytes, 1 = counting bytes, 2 = "flamingo".
   function automatic byteQueue makeMessage(input int n, input int mode);
      byteQueue q;
      for (int i = 0; i < n; i++) begin
         case (mode)
            1:       q.push_back(8'(i));
            2:       q.push_back(flamingo[i % 8]);
            default: q.push_back(8'($urandom_range(0, 255)));
         endcase
      end
      return q;
   endfunction

   // Drive bytes onto the input stream with random idle gaps. A byte is
   // taken on the rising edge that follows a falling edge where in_ready was
   // seen high.
   task automatic applyStimulus(input byteQueue msg, input bit markLast);
      for (int i = 0; i < msg.size(); i++) begin
         int gap;
         int guard;
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
         end
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = msg[i];
         in_last  = markLast && (i == msg.size() - 1);
         guard = 0;
         while (!in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 2000) begin
            failTimeout("byteAccept");
            break;
         end
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Compare the logged commands with the message split into chunks: one
   // command per chunk, init only on the first chunk, final only on the last
   // chunk, length = bytes up to the end of the chunk, and the chunk bytes
   // packed from byte 0 with the rest zero.
   task automatic checkCommands(input byteQueue msg);
      int n;
      int nBlk;
      int lim;
      n    = msg.size();
      nBlk = (n + BLOCK_BYTES - 1) / BLOCK_BYTES;
      checkOutput("cmdCount", cmdLog.size(), nBlk);
      lim = (cmdLog.size() < nBlk) ? cmdLog.size() : nBlk;
      for (int k = 0; k < lim; k++) begin
         logic [BLOCK_BYTES*8-1:0] expBlk;
         int expLen;
         expBlk = '0;
         for (int j = k * BLOCK_BYTES; j < n && j < (k + 1) * BLOCK_BYTES; j++) begin
            expBlk[(j - k * BLOCK_BYTES) * 8 +: 8] = msg[j];
         end
         expLen = ((k + 1) * BLOCK_BYTES < n) ? (k + 1) * BLOCK_BYTES : n;
         checkOutput("cmdInit", cmdLog[k].init, k == 0);
         checkOutput("cmdNext", cmdLog[k].next, k != 0);
         checkOutput("cmdFinal", cmdLog[k].fin, k == nBlk - 1);
         checkOutput("cmdLength", cmdLog[k].len, expLen);
         checkOutput("cmdBlock", cmdLog[k].blk, expBlk);
      end
   endtask

   // Wait for the digest, check that it is held for readyDelay cycles, then
   // accept it and check the return to idle.
   task automatic waitDigest(input int readyDelay);
      int guard;
      logic [DIGEST_BITS-1:0] held;
      guard = 0;
      do begin
         @(negedge clk);
         #2;
         guard++;
      end while (!dgst_valid && guard < 3000);
      if (!dgst_valid) begin
         failTimeout("digestWait");
         return;
      end
      checkOutput("dgstValue", dgst, lastDigest);
      held = dgst;
      repeat (readyDelay) begin
         @(negedge clk);
         #2;
         checkOutput("dgstValidHold", dgst_valid, 1'b1);
         checkOutput("dgstHold", dgst, held);
         checkOutput("inReadyDone", in_ready, 1'b0);
      end
      @(negedge clk);
      dgst_ready = 1'b1;
      @(negedge clk);
      dgst_ready = 1'b0;
      #2;
      checkOutput("dgstValidDrop", dgst_valid, 1'b0);
      checkOutput("inReadyIdle", in_ready, 1'b1);
      checkOutput("lengthClear", length, 0);
      checkOutput("blockClear", block, 0);
   endtask

   // Send one complete message and check all of its commands and its digest.
   task automatic runMessage(input byteQueue msg, input int readyDelay);
      cmdLog.delete();
      applyStimulus(msg, 1'b1);
      waitDigest(readyDelay);
      checkCommands(msg);
   endtask

   // Check that every output reads zero.
   task automatic checkAllZero(input string tag);
      checkOutput({tag, "InReady"}, in_ready, 1'b0);
      checkOutput({tag, "Init"}, init, 1'b0);
      checkOutput({tag, "Next"}, next, 1'b0);
      checkOutput({tag, "Final"}, final_cmd, 1'b0);
      checkOutput({tag, "Block"}, block, 0);
      checkOutput({tag, "Length"}, length, 0);
      checkOutput({tag, "DgstValid"}, dgst_valid, 1'b0);
      checkOutput({tag, "Dgst"}, dgst, 0);
   endtask

   initial begin
      byteQueue msg;
      int guard;

      vectors[0] = '{msgLen: 8,   fillMode: 2, readyDelay: 0, expBlocks: 1, expFinalLen: 8};
      vectors[1] = '{msgLen: 128, fillMode: 1, readyDelay: 0, expBlocks: 1, expFinalLen: 128};
      vectors[2] = '{msgLen: 129, fillMode: 1, readyDelay: 1, expBlocks: 2, expFinalLen: 129};
      vectors[3] = '{msgLen: 1,   fillMode: 0, readyDelay: 5, expBlocks: 1, expFinalLen: 1};
      vectors[4] = '{msgLen: 256, fillMode: 0, readyDelay: 2, expBlocks: 2, expFinalLen: 256};
      vectors[5] = '{msgLen: 300, fillMode: 0, readyDelay: 0, expBlocks: 3, expFinalLen: 300};

      $display("[TB] reset state");
      repeat (2) @(negedge clk);
      #2;
      checkAllZero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #2;
      checkOutput("idleInReady", in_ready, 1'b1);

      $display("[TB] table vectors");
      for (int v = 0; v < 6; v++) begin
         msg = makeMessage(vectors[v].msgLen, vectors[v].fillMode);
         runMessage(msg, vectors[v].readyDelay);
         checkOutput("tblBlocks", cmdLog.size(), vectors[v].expBlocks);
         if (cmdLog.size() > 0) begin
            checkOutput("tblFinalLen", cmdLog[cmdLog.size() - 1].len, vectors[v].expFinalLen);
         end
         if (v == 0 && cmdLog.size() > 0) begin
            checkOutput("flamingoF", cmdLog[0].blk[7:0], 8'h66);
            checkOutput("flamingoO", cmdLog[0].blk[63:56], 8'h6F);
         end
         if (v == 1 && cmdLog.size() > 0) begin
            checkOutput("count127", cmdLog[0].blk[1023:1016], 8'h7F);
         end
      end

      $display("[TB] random messages");
      for (int r = 0; r < 4; r++) begin
         msg = makeMessage($urandom_range(1, 300), 0);
         runMessage(msg, $urandom_range(0, 3));
      end

      $display("[TB] core stall in ISSUE");
      msg = makeMessage(8, 0);
      cmdLog.delete();
      holdLow = 1'b1;
      applyStimulus(msg, 1'b1);
      begin
         logic [BLOCK_BYTES*8-1:0] expBlk;
         expBlk = '0;
         for (int j = 0; j < 8; j++) expBlk[j*8 +: 8] = msg[j];
         repeat (10) begin
            @(negedge clk);
            #2;
            checkOutput("stallInit", init, 1'b0);
            checkOutput("stallNext", next, 1'b0);
            checkOutput("stallInReady", in_ready, 1'b0);
            checkOutput("stallLength", length, 8);
            checkOutput("stallBlock", block, expBlk);
         end
         holdLow = 1'b0;
         @(negedge clk);
         #2;
         checkOutput("releaseInit", init, 1'b1);
         checkOutput("releaseFinal", final_cmd, 1'b1);
         checkOutput("releaseLength", length, 8);
         checkOutput("releaseBlock", block, expBlk);
      end
      waitDigest(0);
      checkCommands(msg);

      $display("[TB] reset during BUSY");
      msg = makeMessage(128, 0);
      cmdLog.delete();
      applyStimulus(msg, 1'b0);
      guard = 0;
      while (cmdLog.size() < 1 && guard < 500) begin
         @(negedge clk);
         #2;
         guard++;
      end
      if (cmdLog.size() < 1) begin
         failTimeout("firstBlockCmd");
      end else begin
         checkOutput("partInit", cmdLog[0].init, 1'b1);
         checkOutput("partFinal", cmdLog[0].fin, 1'b0);
         checkOutput("partLength", cmdLog[0].len, 128);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkAllZero("midReset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      msg = makeMessage(8, 2);
      runMessage(msg, 0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
